axi_vec_rd_slave: RTL and testbench

AXI_VEC_RD_SLAVE -- requirements
Module: axi_vec_rd_slave

---
 rtl/axi_vec_pkg.sv | 21 ++
 rtl/axi_vec_ram.sv | 32 +++
 rtl/axi_vec_rd_slave.sv | 183 ++++++++++++++++++
 tb/tb_axi_vec_rd_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_vec_pkg.sv
// Shared constants, FSM state type and burst-legality helper for the AXI vector read slave.
package axi_vec_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Only FIXED/INCR bursts of 4-byte beats are served with real data.
    function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == 3'd2);
    endfunction

endpackage

// File: rtl/axi_vec_ram.sv
// Backing store: one write port and one synchronous read port returning the pre-write word.
module axi_vec_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; holds its word while re is low so a stalled beat stays stable.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/axi_vec_rd_slave.sv
// AXI4 read-only slave serving single-outstanding bursts from a preloadable word store.
// Build option: AXI_RD_SLV_PATTERN_EN returns word index + 1 instead of stored data.
module axi_vec_rd_slave
    import axi_vec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_W-1:0]          s_axi_arid,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [ID_W-1:0]          s_axi_rid,
    output logic [DATA_W-1:0]        s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [15:0]              err_cnt
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    state_t            state_r, state_s;
    logic              arready_r, rvalid_r, rlast_r, data_ok_r, fixed_r, bad_r;
    logic [1:0]        rresp_r;
    logic [ID_W-1:0]   rid_r;
    logic [7:0]        cnt_r, len_r;
    logic [IDX_W-1:0]  idx_r, rd_idx_s;
    logic [15:0]       err_cnt_r;
    logic              ar_hs_s, beat_hs_s, rd_en_s, rd_bad_s, rd_last_s, rd_oor_s;
    logic [DATA_W-1:0] ram_q_s, word_s;
    logic              ram_we_s, unused_s;

    // Next state plus the address/attributes of the beat to fetch next.
    always_comb begin
        state_s   = state_r;
        ar_hs_s   = 1'b0;
        beat_hs_s = 1'b0;
        rd_en_s   = 1'b0;
        rd_idx_s  = idx_r;
        rd_bad_s  = bad_r;
        rd_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ar_hs_s = s_axi_arvalid & arready_r;
                if (ar_hs_s) begin
                    state_s   = ST_BURST;
                    rd_en_s   = 1'b1;
                    rd_idx_s  = s_axi_araddr[ADDR_W-1:2];
                    rd_bad_s  = ~burst_legal(s_axi_arburst, s_axi_arsize);
                    rd_last_s = (s_axi_arlen == 8'd0);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                beat_hs_s = rvalid_r & s_axi_rready;
                if (beat_hs_s && rlast_r) begin
                    state_s = ST_IDLE;
                end else if (beat_hs_s) begin
                    rd_en_s   = 1'b1;
                    rd_idx_s  = fixed_r ? idx_r : (idx_r + IDX_W'(1));
                    rd_last_s = ((cnt_r + 8'd1) == len_r);
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign rd_oor_s = (rd_idx_s >= DEPTH_IDX);

    // FSM state and AR-channel ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            arready_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            arready_r <= (state_s == ST_IDLE);
        end
    end

    // Burst context and registered R-channel beat attributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rid_r     <= '0;
            data_ok_r <= 1'b0;
            idx_r     <= '0;
            cnt_r     <= 8'd0;
            len_r     <= 8'd0;
            fixed_r   <= 1'b0;
            bad_r     <= 1'b0;
            err_cnt_r <= 16'd0;
        end else begin
            if (ar_hs_s) begin
                rid_r    <= s_axi_arid;
                len_r    <= s_axi_arlen;
                fixed_r  <= (s_axi_arburst == BURST_FIXED);
                bad_r    <= rd_bad_s;
                cnt_r    <= 8'd0;
                rvalid_r <= 1'b1;
            end else if (beat_hs_s) begin
                cnt_r    <= cnt_r + 8'd1;
                rvalid_r <= ~rlast_r;
            end
            if (rd_en_s) begin
                idx_r     <= rd_idx_s;
                rlast_r   <= rd_last_s;
                rresp_r   <= (rd_bad_s | rd_oor_s) ? RESP_SLVERR : RESP_OKAY;
                data_ok_r <= ~(rd_bad_s | rd_oor_s);
            end else if (beat_hs_s) begin
                rlast_r <= 1'b0;
            end
            if (beat_hs_s && (rresp_r == RESP_SLVERR) && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

`ifdef AXI_RD_SLV_PATTERN_EN
    logic [DATA_W-1:0] pat_r;

    // Synthetic beat data captured alongside each fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= '0;
        end else if (rd_en_s) begin
            pat_r <= DATA_W'(rd_idx_s) + DATA_W'(1);
        end
    end

    assign ram_we_s = 1'b0;
    assign word_s   = pat_r;
    assign unused_s = ^{s_axi_araddr[1:0], ram_q_s};
`else
    assign ram_we_s = ld_en;
    assign word_s   = ram_q_s;
    assign unused_s = ^s_axi_araddr[1:0];
`endif

    axi_vec_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (rd_en_s),
        .raddr (rd_idx_s[MEM_AW-1:0]),
        .rdata (ram_q_s)
    );

    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rlast   = rlast_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rdata   = data_ok_r ? word_s : '0;
    assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_axi_vec_rd_slave.sv
// Directed self-checking bench for axi_vec_rd_slave (default 32/32/4/512 configuration).
module tb_axi_vec_rd_slave;
    import axi_vec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] err_cnt;

    int total = 0;
    int bad = 0;
    int err_model = 0;
    logic [31:0] mem_model [512];

    axi_vec_rd_slave dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int idx);
`ifdef AXI_RD_SLV_PATTERN_EN
        return 32'(idx + 1);
`else
        return mem_model[idx];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("ar_timeout", 32'(n), 32'd0);
        step();
        s_axi_arvalid = 1'b0;
    endtask

    // Drains nbeats, checking every cycle the beat is presented (so stalls verify stability).
    task automatic recv_burst(input int nbeats, input int first, input int stride, input bit illegal,
                              input logic [3:0] id, input bit stall);
        int k = 0;
        int cyc = 0;
        int idx;
        bit err;
        while (k < nbeats && cyc < 3000) begin
            s_axi_rready = stall ? (cyc % 3 == 0) : 1'b1;
            idx = first + k * stride;
            err = illegal || (idx >= 512);
            check("rvalid", 32'(s_axi_rvalid), 32'd1);
            check("arready_busy", 32'(s_axi_arready), 32'd0);
            check("rdata", s_axi_rdata, err ? 32'd0 : exp_word(idx));
            check("rresp", 32'(s_axi_rresp), err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
            check("rlast", 32'(s_axi_rlast), 32'(k == nbeats - 1));
            check("rid", 32'(s_axi_rid), 32'(id));
            if (s_axi_rvalid && s_axi_rready) begin
                if (err) err_model++;
                k++;
            end
            step();
            cyc++;
        end
        if (k < nbeats) check("burst_timeout", 32'(k), 32'(nbeats));
        s_axi_rready = 1'b0;
        check("rvalid_end", 32'(s_axi_rvalid), 32'd0);
        check("arready_end", 32'(s_axi_arready), 32'd1);
        check("err_cnt", 32'(err_cnt), 32'(err_model));
    endtask

    initial begin
        rst = 1'b1;
        s_axi_arid = 4'd0; s_axi_araddr = 32'd0; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; ld_en = 1'b0; ld_addr = 9'd0; ld_data = 32'd0;

        // Reset state.
        step();
        step();
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_arready", 32'(s_axi_arready), 32'd1);
        check("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("post_rst_rlast", 32'(s_axi_rlast), 32'd0);
        check("post_rst_rresp", 32'(s_axi_rresp), 32'd0);
        check("post_rst_rid", 32'(s_axi_rid), 32'd0);
        check("post_rst_rdata", s_axi_rdata, 32'd0);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        // Preload words 0..255 = i, plus the two words at the top of the store.
        for (int i = 0; i < 258; i++) begin
            ld_en   = 1'b1;
            ld_addr = (i < 256) ? 9'(i) : 9'(254 + i);
            ld_data = (i < 256) ? 32'(i) : 32'hBEEF_0000 + 32'(i);
            mem_model[ld_addr] = ld_data;
            step();
        end
        ld_en = 1'b0;

        // Full 256-beat INCR burst with rready held high.
        send_ar(4'h3, 32'h0000_0000, 8'd255, 3'd2, BURST_INCR);
        recv_burst(256, 0, 1, 1'b0, 4'h3, 1'b0);

        // Back-pressure: rready 1,0,0,1... over words 4..7.
        send_ar(4'h5, 32'h0000_0010, 8'd3, 3'd2, BURST_INCR);
        recv_burst(4, 4, 1, 1'b0, 4'h5, 1'b1);

        // Run off the end of the store: words 510,511 OK, 512,513 SLVERR.
        send_ar(4'h9, 32'h0000_07F8, 8'd3, 3'd2, BURST_INCR);
        recv_burst(4, 510, 1, 1'b0, 4'h9, 1'b0);
        check("edge_err_cnt", 32'(err_cnt), 32'd2);

        // Unsupported bursts: WRAP, reserved type, narrow size.
        send_ar(4'hA, 32'h0000_0000, 8'd1, 3'd2, BURST_WRAP);
        recv_burst(2, 0, 1, 1'b1, 4'hA, 1'b0);
        send_ar(4'hB, 32'h0000_0004, 8'd0, 3'd2, 2'b11);
        recv_burst(1, 1, 1, 1'b1, 4'hB, 1'b0);
        send_ar(4'hC, 32'h0000_0004, 8'd0, 3'd1, BURST_INCR);
        recv_burst(1, 1, 1, 1'b1, 4'hC, 1'b0);
        check("bad_burst_err_cnt", 32'(err_cnt), 32'd6);

        // FIXED burst repeats word 2.
        send_ar(4'h2, 32'h0000_0008, 8'd2, 3'd2, BURST_FIXED);
        recv_burst(3, 2, 0, 1'b0, 4'h2, 1'b0);

        // Preload hitting the word fetched in the same cycle returns the old word.
        s_axi_arid = 4'hD; s_axi_araddr = 32'h0000_0040; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
        ld_en = 1'b1; ld_addr = 9'd16; ld_data = 32'hDEAD_0016;
        check("coll_arready", 32'(s_axi_arready), 32'd1);
        step();
        s_axi_arvalid = 1'b0;
        ld_en = 1'b0;
        recv_burst(1, 16, 1, 1'b0, 4'hD, 1'b0);
        mem_model[16] = 32'hDEAD_0016;
        send_ar(4'hE, 32'h0000_0040, 8'd0, 3'd2, BURST_INCR);
        recv_burst(1, 16, 1, 1'b0, 4'hE, 1'b0);

        // Reset mid-burst after beat 2 of an 8-beat burst.
        send_ar(4'h6, 32'h0000_0000, 8'd7, 3'd2, BURST_INCR);
        s_axi_rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("pre_rst_rdata", s_axi_rdata, exp_word(k));
            step();
        end
        rst = 1'b1;
        s_axi_rready = 1'b0;
        step();
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("mid_rst_arready", 32'(s_axi_arready), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        err_model = 0;
        step();
        check("after_rst_arready", 32'(s_axi_arready), 32'd1);
        check("after_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        send_ar(4'h7, 32'h0000_0000, 8'd0, 3'd2, BURST_INCR);
        recv_burst(1, 0, 1, 1'b0, 4'h7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
